// File: rtl/wb_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ext_pkg
// Description : Shared types and constants for the Wishbone external guard:
//               FSM state encoding, error data word, local slot number and
//               local register offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ext_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_LOCAL = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA      = 32'hDEAD_BEEF;
    localparam logic [1:0]  LOCAL_SLOT    = 2'd3;

    localparam logic [1:0]  OFF_STATUS    = 2'd0;
    localparam logic [1:0]  OFF_LAST_ADDR = 2'd1;

endpackage
`default_nettype wire

// File: rtl/wb_ext_status.sv
`default_nettype none
// ============================================================================
// Module      : wb_ext_status
// Description : Local status registers of the guard: saturating timeout
//               counter, sticky error flag, address of the latest timeout
//               and the local read multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ext_status
    import wb_ext_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tmo,
    input  logic [31:0] i_tmo_addr,
    input  logic        i_clr,
    input  logic [1:0]  i_rd_off,
    output logic [31:0] o_rd_data
);

    logic [15:0] r_tmo_count;
    logic        r_sticky_err;
    logic [31:0] r_last_addr;

    // Timeout counter saturates; a STATUS write clears it together with the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_count  <= 16'd0;
            r_sticky_err <= 1'b0;
        end else if (i_clr) begin
            r_tmo_count  <= 16'd0;
            r_sticky_err <= 1'b0;
        end else if (i_tmo) begin
            if (r_tmo_count != 16'hFFFF) begin
                r_tmo_count <= r_tmo_count + 16'd1;
            end
            r_sticky_err <= 1'b1;
        end
    end

    // Remember the address of the most recent timed-out transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= 32'd0;
        end else if (i_tmo) begin
            r_last_addr <= i_tmo_addr;
        end
    end

    // Local read multiplexer; unused offsets read as zero.
    always_comb begin
        o_rd_data = 32'd0;
        case (i_rd_off)
            OFF_STATUS:    o_rd_data = {15'd0, r_sticky_err, r_tmo_count};
            OFF_LAST_ADDR: o_rd_data = r_last_addr;
            default:       o_rd_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_ext_guard.sv
`default_nettype none
// ============================================================================
// Module      : wb_ext_guard
// Description : Wishbone guard forwarding master requests to three external
//               slave slots with a response timeout, plus a local slot that
//               exposes timeout status registers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ext_guard
    import wb_ext_pkg::*;
#(
    parameter int SLOT_LSB    = 8,
    parameter int TIMEOUT_CYC = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wdata,
    input  logic [3:0]  wb_sel,
    output logic [31:0] wb_rdata,
    output logic        wb_ack_ext,
    output logic        s_cyc,
    output logic [2:0]  s_stb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic [3:0]  s_sel,
    input  logic [95:0] s_rdata,
    input  logic [2:0]  s_ack
);

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [1:0]  r_slot;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_ack;

    logic [1:0]  w_req_slot;
    logic        w_slot_ack;
    logic [31:0] w_slot_rdata;
    logic [31:0] w_local_rdata;
    logic        w_tmo;
    logic        w_clr;
    logic        w_load;
    logic [31:0] w_load_data;

    assign w_req_slot = wb_addr[SLOT_LSB+1:SLOT_LSB];

    // Select ack and read data of the addressed slave slot.
    always_comb begin
        w_slot_ack   = 1'b0;
        w_slot_rdata = 32'd0;
        case (r_slot)
            2'd0: begin w_slot_ack = s_ack[0]; w_slot_rdata = s_rdata[31:0];  end
            2'd1: begin w_slot_ack = s_ack[1]; w_slot_rdata = s_rdata[63:32]; end
            2'd2: begin w_slot_ack = s_ack[2]; w_slot_rdata = s_rdata[95:64]; end
            default: begin w_slot_ack = 1'b0; w_slot_rdata = 32'd0; end
        endcase
    end

    // Next-state logic with response load, timeout and STATUS-clear strobes.
    always_comb begin
        w_next      = r_state;
        w_tmo       = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_load_data = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    w_next = (w_req_slot == LOCAL_SLOT) ? ST_LOCAL : ST_REQ;
                end
            end
            ST_REQ: begin
                // A master abort takes precedence over any slave response.
                if (!wb_cyc) begin
                    w_next = ST_IDLE;
                end else if (w_slot_ack) begin
                    w_next      = ST_RESP;
                    w_load      = 1'b1;
                    w_load_data = r_we ? 32'd0 : w_slot_rdata;
                end else if (r_cnt == c_tmo_last) begin
                    w_next      = ST_RESP;
                    w_load      = 1'b1;
                    w_load_data = ERR_DATA;
                    w_tmo       = 1'b1;
                end
            end
            ST_LOCAL: begin
                if (!wb_cyc) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next      = ST_RESP;
                    w_load      = 1'b1;
                    w_load_data = r_we ? 32'd0 : w_local_rdata;
                    w_clr       = r_we && (r_addr[3:2] == OFF_STATUS);
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the master request when it is accepted from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_slot  <= 2'd0;
        end else if (r_state == ST_IDLE && wb_cyc && wb_stb) begin
            r_addr  <= wb_addr;
            r_wdata <= wb_wdata;
            r_we    <= wb_we;
            r_sel   <= wb_sel;
            r_slot  <= w_req_slot;
        end
    end

    // Cycles spent in REQ; held at zero outside REQ so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    // Registered response: ack pulses during RESP, read data holds until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack <= w_load;
            if (w_load) begin
                r_rdata <= w_load_data;
            end
        end
    end

    wb_ext_status u_status (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tmo      (w_tmo),
        .i_tmo_addr (r_addr),
        .i_clr      (w_clr),
        .i_rd_off   (r_addr[3:2]),
        .o_rd_data  (w_local_rdata)
    );

    assign wb_ack_ext = r_ack;
    assign wb_rdata   = r_rdata;
    assign s_cyc      = (r_state == ST_REQ);
    assign s_stb      = (r_state == ST_REQ) ? (3'b001 << r_slot) : 3'b000;
    assign s_addr     = r_addr;
    assign s_wdata    = r_wdata;
    assign s_we       = r_we;
    assign s_sel      = r_sel;

endmodule
`default_nettype wire
